// File: rtl/recip_div_8bit.sv
// rtl/recip_div_8bit.sv - radix-2 restoring divider recovering X = floor((P << WIDTH) / Y)
//
// Purpose: sequential inverse of the truncated WIDTH-bit multiplier. It takes a product
// high word P and a multiplicand Y, then produces one quotient bit per clock.
// Valid/ready handshakes are used on both the input and the output side.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      P/Y present
//   in_ready   out  1      operands accepted (IDLE only)
//   P          in   WIDTH  dividend high word (low WIDTH dividend bits are zero)
//   Y          in   WIDTH  divisor
//   out_valid  out  1      X/R/ovf/dbz valid (DONE only)
//   out_ready  in   1      consumer accepts result
//   X          out  WIDTH  quotient
//   R          out  WIDTH  remainder
//   ovf        out  1      P >= Y with Y != 0: quotient does not fit
//   dbz        out  1      Y == 0
module recip_div_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] R,
    output logic             ovf,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH:0]    rem_q, rem_d;
    logic [WIDTH-2:0]  quo_q, quo_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic              ovf_q, ovf_d;
    logic              dbz_q, dbz_d;

    // Datapath for a single restoring step.
    logic [WIDTH:0]    rem_shift;
    logic [WIDTH:0]    rem_next;
    logic              q_bit;
    logic [WIDTH-1:0]  quo_shift;

    always_comb begin
        // The remainder is always below Y after a step, so its top bit is zero.
        // Shifting the full WIDTH+1 word therefore never loses information.
        rem_shift = rem_q << 1;
        q_bit     = (rem_shift >= {1'b0, y_q});
        rem_next  = q_bit ? (rem_shift - {1'b0, y_q}) : rem_shift;
        // The last step writes its bit straight into X.
        // Only WIDTH-1 quotient bits need to be stored between steps.
        quo_shift = {quo_q, q_bit};
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        x_d     = x_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    y_d = Y;
                    if (Y == '0) begin
                        x_d     = '1;
                        r_d     = '0;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = ST_DONE;
                    end else if (P >= Y) begin
                        x_d     = '1;
                        r_d     = '0;
                        ovf_d   = 1'b1;
                        dbz_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        rem_d   = {1'b0, P};
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                rem_d = rem_next;
                quo_d = quo_shift[WIDTH-2:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    x_d     = quo_shift;
                    r_d     = rem_next[WIDTH-1:0];
                    ovf_d   = 1'b0;
                    dbz_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            x_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            x_q     <= x_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign X         = x_q;
    assign R         = r_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_recip_div_8bit.sv
// tb/tb_recip_div_8bit.sv - scoreboard bench for recip_div_8bit
module tb_recip_div_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] P;
    logic [7:0] Y;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] X;
    logic [7:0] R;
    logic       ovf;
    logic       dbz;

    recip_div_8bit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .P         (P),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .X         (X),
        .R         (R),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] r;
        logic       ovf;
        logic       dbz;
        logic [7:0] lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] p, input logic [7:0] y);
        exp_t e;
        logic [15:0] num;
        num = {p, 8'h00};
        if (y == 8'h00) begin
            e = '{x: 8'hFF, r: 8'h00, ovf: 1'b0, dbz: 1'b1, lat: 8'd1};
        end else if (p >= y) begin
            e = '{x: 8'hFF, r: 8'h00, ovf: 1'b1, dbz: 1'b0, lat: 8'd1};
        end else begin
            e.x   = 8'(num / {8'h00, y});
            e.r   = 8'(num % {8'h00, y});
            e.ovf = 1'b0;
            e.dbz = 1'b0;
            e.lat = 8'd9;
        end
        return e;
    endfunction

    // Operands are driven at the negedge, the accept is at the next posedge, and the
    // task returns at the following negedge. The pins are scrambled right afterwards
    // so that any use of live P/Y instead of the captured operands shows up.
    task automatic send(input logic [7:0] p, input logic [7:0] y);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); @(negedge clk); guard++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        P = p;
        Y = y;
        @(posedge clk);
        sb.push_back(model(p, y));
        @(negedge clk);
        in_valid = 1'b0;
        P = 8'($urandom);
        Y = 8'($urandom);
    endtask

    task automatic recv(input int hold, output logic [7:0] gx, output logic [7:0] gr);
        int   lat = 1;
        exp_t e;
        while (!out_valid && lat < 40) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        e = sb.pop_front();
        chk("latency", 32'(lat), 32'(e.lat));
        chk("X", 32'(X), 32'(e.x));
        chk("R", 32'(R), 32'(e.r));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("dbz", 32'(dbz), 32'(e.dbz));
        gx = X;
        gr = R;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            P = 8'($urandom);
            Y = 8'($urandom);
            @(posedge clk); @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_X", 32'(X), 32'(e.x));
            chk("hold_R", 32'(R), 32'(e.r));
            chk("hold_flags", 32'({ovf, dbz}), 32'({e.ovf, e.dbz}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic op(input logic [7:0] p, input logic [7:0] y, input int hold);
        logic [7:0] gx, gr;
        send(p, y);
        recv(hold, gx, gr);
    endtask

    initial begin
        logic [7:0] gx, gr;
        logic [7:0] rp, ry;
        exp_t       dropped;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        P         = 8'h00;
        Y         = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_X", 32'(X), 32'd0);
        chk("rst_R", 32'(R), 32'd0);
        chk("rst_flags", 32'({ovf, dbz}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        op(8'h40, 8'h80, 0);
        op(8'h01, 8'h03, 0);
        op(8'h7F, 8'hFF, 0);
        op(8'h5A, 8'h00, 0);
        op(8'h00, 8'h00, 0);
        op(8'h90, 8'h80, 0);
        op(8'h80, 8'h80, 0);
        op(8'h00, 8'h01, 0);
        op(8'hFE, 8'hFF, 0);
        op(8'h01, 8'h03, 5);
        op(8'h20, 8'h00, 3);

        // Abort a division mid-way through BUSY.
        send(8'h01, 8'h03);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dropped = sb.pop_back();
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_valid_after", 32'(out_valid), 32'd0);
        op(8'h01, 8'h03, 0);

        for (int i = 0; i < 24; i++) begin
            ry = 8'($urandom_range(1, 255));
            rp = 8'($urandom_range(0, int'(ry) - 1));
            send(rp, ry);
            recv(0, gx, gr);
            chk("sweep_identity", 32'({8'h00, gx} * {8'h00, ry} + {8'h00, gr}), 32'({rp, 8'h00}));
            chk("sweep_r_lt_y", 32'(gr < ry), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
